// File: rtl/osd_textwriter_if.sv
// Input side of the OSD text writer: char/control stream plus cursor load.
// Master is the OSD control logic, slave is the text writer.
interface osd_textwriter_if #(
    parameter int COL_W = 5,
    parameter int ROW_W = 3
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             inverse;
    logic             goto_valid;
    logic [COL_W-1:0] goto_x;
    logic [ROW_W-1:0] goto_y;

    modport master (
        output in_data,
        output in_valid,
        output inverse,
        output goto_valid,
        output goto_x,
        output goto_y,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  inverse,
        input  goto_valid,
        input  goto_x,
        input  goto_y,
        output in_ready
    );
endinterface

// File: rtl/osd_textwriter.sv
// OSD screenbuffer writer: byte stream -> {row,col} addressed writes with cursor.
// Define OSD_CLEAR_ON_RESET_EN to start with a full clear sweep out of reset.
module osd_textwriter #(
    parameter int         COL_W     = 5,
    parameter int         ROW_W     = 3,
    parameter logic [7:0] FILL_CODE = 8'h20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    osd_textwriter_if.slave        bus,
    output logic [COL_W+ROW_W-1:0] address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   busy,
    output logic [COL_W-1:0]       cursor_x,
    output logic [ROW_W-1:0]       cursor_y
);
    localparam int AW = COL_W + ROW_W;

    localparam logic [6:0] C_BS = 7'h08;
    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_FF = 7'h0C;
    localparam logic [6:0] C_CR = 7'h0D;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

`ifdef OSD_CLEAR_ON_RESET_EN
    localparam state_e RST_STATE = S_CLEAR;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e           state_q, state_d;
    logic [COL_W-1:0] cx_q, cx_d;
    logic [ROW_W-1:0] cy_q, cy_d;
    logic [AW-1:0]    clr_q, clr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             wren_q, wren_d;

    logic [6:0]       code;
    logic             idle;
    logic             accept;
    logic             unused_bit7;

    assign code        = bus.in_data[6:0];
    assign unused_bit7 = bus.in_data[7];
    assign idle        = (state_q == S_IDLE);
    assign accept      = ce & bus.in_valid & idle & ~bus.goto_valid;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        clr_d   = clr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        if (ce) begin
            unique case (state_q)
                S_CLEAR: begin
                    wren_d = 1'b1;
                    addr_d = clr_q;
                    data_d = FILL_CODE;
                    clr_d  = clr_q + 1'b1;
                    if (&clr_q) begin
                        state_d = S_IDLE;
                        cx_d    = '0;
                        cy_d    = '0;
                    end
                end
                S_IDLE: begin
                    if (bus.goto_valid) begin
                        cx_d = bus.goto_x;
                        cy_d = bus.goto_y;
                    end else if (accept) begin
                        unique case (1'b1)
                            (code >= 7'h20): begin
                                wren_d = 1'b1;
                                addr_d = {cy_q, cx_q};
                                data_d = {bus.inverse, code};
                                cx_d   = cx_q + 1'b1;
                                if (&cx_q)
                                    cy_d = cy_q + 1'b1;
                            end
                            (code == C_CR): begin
                                cx_d = '0;
                            end
                            (code == C_LF): begin
                                cx_d = '0;
                                cy_d = cy_q + 1'b1;
                            end
                            (code == C_BS): begin
                                if (cx_q != '0) begin
                                    cx_d   = cx_q - 1'b1;
                                    wren_d = 1'b1;
                                    addr_d = {cy_q, cx_q - 1'b1};
                                    data_d = FILL_CODE;
                                end
                            end
                            (code == C_FF): begin
                                state_d = S_CLEAR;
                                clr_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            cx_q    <= '0;
            cy_q    <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
        end
    end

    assign bus.in_ready = idle;
    assign busy         = ~idle;
    assign address      = addr_q;
    assign data         = data_q;
    assign wren         = wren_q;
    assign cursor_x     = cx_q;
    assign cursor_y     = cy_q;
endmodule
